// File: rtl/fir_serial_mac.sv
// Time-multiplexed signed FIR filter: one shared MAC, run-time loadable coefficients,
// and a valid/ready sample handshake on a bus shared by samples and coefficients.
module fir_serial_mac #(
    parameter int N_TAPS = 5,
    parameter int BW_IN  = 6,
    parameter int BW_OUT = 8,
    parameter int SHIFT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              coef_load,
    input  logic [BW_IN-1:0]  x_in,
    output logic              in_ready,
    output logic [BW_OUT-1:0] y_out,
    output logic              out_valid,
    output logic              coef_ready
);

    localparam int KW     = $clog2(N_TAPS);
    localparam int BW_ACC = 2 * BW_IN + KW;
    localparam int RND    = (2 ** SHIFT) / 2;
    localparam logic [KW-1:0] LAST = KW'(N_TAPS - 1);
    localparam logic signed [BW_ACC:0] SAT_MAX = (BW_ACC + 1)'(2 ** (BW_OUT - 1) - 1);
    localparam logic signed [BW_ACC:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [BW_IN-1:0]   x [N_TAPS];
    logic signed [BW_IN-1:0]   c [N_TAPS];
    logic [KW-1:0]             cptr;
    logic [KW-1:0]             k;
    logic signed [BW_ACC-1:0]  acc;
    logic signed [2*BW_IN-1:0] prod;
    logic signed [BW_ACC:0]    rounded;
    logic signed [BW_ACC:0]    scaled;
    logic [BW_OUT-1:0]         sat;

    // Handshake: a beat transfers on a rising edge where in_valid and in_ready are both high;
    // in_ready is high only in IDLE, so the source holds its beat through MAC and DONE.
    assign in_ready = (state == IDLE);

    assign prod    = x[k] * c[k];
    assign rounded = {acc[BW_ACC-1], acc} + (BW_ACC + 1)'(RND);
    assign scaled  = rounded >>> SHIFT;

    always_comb begin
        sat = scaled[BW_OUT-1:0];
        if (scaled > SAT_MAX) begin
            sat = SAT_MAX[BW_OUT-1:0];
        end else if (scaled < SAT_MIN) begin
            sat = SAT_MIN[BW_OUT-1:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid && !coef_load && coef_ready) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if (k == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            y_out      <= '0;
            coef_ready <= 1'b0;
            cptr       <= '0;
            k          <= '0;
            acc        <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                x[i] <= '0;
                c[i] <= '0;
            end
        end else begin
            state     <= state_next;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && coef_load) begin
                        c[cptr] <= x_in;
                        if (cptr == LAST) begin
                            cptr       <= '0;
                            coef_ready <= 1'b1;
                        end else begin
                            cptr <= cptr + 1'b1;
                            // First beat of a fresh bank invalidates the old one.
                            if (cptr == '0 && coef_ready) begin
                                coef_ready <= 1'b0;
                            end
                        end
                    end else if (in_valid && coef_ready) begin
                        x[0] <= x_in;
                        for (int i = 1; i < N_TAPS; i++) begin
                            x[i] <= x[i-1];
                        end
                        acc <= '0;
                        k   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + {{KW{prod[2*BW_IN-1]}}, prod};
                    k   <= (k == LAST) ? '0 : k + 1'b1;
                end
                DONE: begin
                    y_out     <= sat;
                    out_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench for fir_serial_mac: two instances (SHIFT=0 and SHIFT=4) share one input bus,
// a behavioural model predicts each output and a negedge monitor checks it with latency.
module tb_fir_serial_mac;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       coef_load;
    logic [5:0] x_in;

    logic       in_ready0, out_valid0, coef_ready0;
    logic [7:0] y_out0;
    logic       in_ready4, out_valid4, coef_ready4;
    logic [7:0] y_out4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int ready_low = 0;

    logic signed [31:0] exp0_q[$];
    logic signed [31:0] exp4_q[$];
    int lat_q[$];

    int mx[5];
    int mc[5];
    int mptr = 0;
    bit mcr = 0;

    fir_serial_mac #(.N_TAPS(5), .BW_IN(6), .BW_OUT(8), .SHIFT(0)) d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .coef_load(coef_load), .x_in(x_in),
        .in_ready(in_ready0), .y_out(y_out0), .out_valid(out_valid0), .coef_ready(coef_ready0)
    );

    fir_serial_mac #(.N_TAPS(5), .BW_IN(6), .BW_OUT(8), .SHIFT(4)) d4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .coef_load(coef_load), .x_in(x_in),
        .in_ready(in_ready4), .y_out(y_out4), .out_valid(out_valid4), .coef_ready(coef_ready4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (!in_ready0) ready_low++;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] expect_y(input int acc, input int s);
        int r;
        r = (acc + ((s > 0) ? (1 << (s - 1)) : 0)) >>> s;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic model_accept(input bit cl, input int v);
        int acc;
        if (cl) begin
            mc[mptr] = v;
            if (mptr == 4) begin
                mptr = 0;
                mcr = 1;
            end else begin
                if (mptr == 0 && mcr) mcr = 0;
                mptr++;
            end
        end else if (mcr) begin
            for (int i = 4; i > 0; i--) mx[i] = mx[i-1];
            mx[0] = v;
            acc = 0;
            for (int i = 0; i < 5; i++) acc += mx[i] * mc[i];
            exp0_q.push_back(expect_y(acc, 0));
            exp4_q.push_back(expect_y(acc, 4));
            lat_q.push_back(acc_cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            mx[i] = 0;
            mc[i] = 0;
        end
        mptr = 0;
        mcr = 0;
        exp0_q.delete();
        exp4_q.delete();
        lat_q.delete();
    endtask

    task automatic send(input bit cl, input int v);
        int budget;
        budget = 40;
        @(negedge clk);
        in_valid  = 1'b1;
        coef_load = cl;
        x_in      = 6'(v);
        while (!in_ready0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("accept_wait", in_ready0, 1);
        if (!in_ready0) begin
            in_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        model_accept(cl, v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 60;
        while ((exp0_q.size() != 0 || exp4_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain", exp0_q.size() + exp4_q.size(), 0);
    endtask

    always @(negedge clk) begin
        logic signed [31:0] e;
        int lat;
        if (!reset && out_valid0) begin
            if (exp0_q.size() == 0) begin
                check("spurious_out_valid0", 1, 0);
            end else begin
                e = exp0_q.pop_front();
                check("y_shift0", $signed(y_out0), e);
                lat = lat_q.pop_front();
                check("latency", cyc - lat, 7);
            end
        end
        if (!reset && out_valid4) begin
            if (exp4_q.size() == 0) begin
                check("spurious_out_valid4", 1, 0);
            end else begin
                e = exp4_q.pop_front();
                check("y_shift4", $signed(y_out4), e);
            end
        end
    end

    initial begin
        int prev;
        int v;
        reset     = 1'b1;
        in_valid  = 1'b0;
        coef_load = 1'b0;
        x_in      = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready0, 1);
        check("rst_out_valid", out_valid0, 0);
        check("rst_y_out0", $signed(y_out0), 0);
        check("rst_y_out4", $signed(y_out4), 0);
        check("rst_coef_ready", coef_ready0, 0);
        reset = 1'b0;

        // Samples before any coefficients are consumed silently.
        send(0, 5);
        send(0, -7);
        repeat (10) @(negedge clk);
        check("nocoef_coef_ready", coef_ready0, 0);
        check("nocoef_in_ready", in_ready0, 1);

        // Load 1..5 and impulse.
        for (int i = 1; i <= 5; i++) begin
            send(1, i);
            check("load_coef_ready", coef_ready4, (i == 5) ? 1 : 0);
        end
        send(0, 1);
        for (int i = 0; i < 5; i++) send(0, 0);
        wait_drain();
        check("impulse_last", $signed(y_out0), 0);

        // Fill delay line, then reload 0,0,0,0,1 and confirm the line survives.
        send(0, 7);
        send(0, -3);
        send(0, 5);
        send(0, 9);
        send(0, -6);
        wait_drain();
        for (int i = 0; i < 5; i++) begin
            send(1, (i == 4) ? 1 : 0);
            check("reload_coef_ready", coef_ready0, (i == 4) ? 1 : 0);
        end
        send(0, 2);
        wait_drain();
        check("reload_tap4", $signed(y_out0), -3);

        // Rounding ties toward +inf.
        for (int i = 0; i < 5; i++) send(1, (i == 0) ? 1 : 0);
        send(0, 24);
        wait_drain();
        check("round_pos", $signed(y_out4), 2);
        send(0, -24);
        wait_drain();
        check("round_neg", $signed(y_out4), -1);

        // Saturation at both rails.
        for (int i = 0; i < 5; i++) send(1, 31);
        for (int i = 0; i < 5; i++) send(0, 31);
        wait_drain();
        check("sat_pos", $signed(y_out4), 127);
        for (int i = 0; i < 5; i++) send(1, -32);
        for (int i = 0; i < 5; i++) send(0, 31);
        wait_drain();
        check("sat_neg", $signed(y_out4), -128);

        // Streaming with in_valid held: one accept per 7 cycles.
        for (int i = 0; i < 5; i++) send(1, int'($urandom_range(0, 63)) - 32);
        send(0, int'($urandom_range(0, 63)) - 32);
        prev = acc_cyc;
        ready_low = 0;
        for (int i = 0; i < 2; i++) begin
            v = int'($urandom_range(0, 63)) - 32;
            send(0, v);
            check("stream_spacing", acc_cyc - prev, 7);
            prev = acc_cyc;
        end
        check("stream_ready_low", ready_low, 12);
        wait_drain();

        // Reset two cycles into a computation.
        send(0, 11);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst_out_valid", out_valid0, 0);
        check("midrst_y_out", $signed(y_out4), 0);
        check("midrst_coef_ready", coef_ready4, 0);
        check("midrst_in_ready", in_ready4, 1);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_quiet_queue", exp0_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
